// File: rtl/ir_demod_if.sv
// Control and status bundle between the UART IR CSR/pad side and the IR carrier demodulator.
// The master drives enable, raw level and qualification settings; the slave returns the baseband result.
interface ir_demod_if #(
  parameter int W_DIV   = 12,
  parameter int W_EDGES = 4
);
  logic               en;
  logic               din;
  logic               invert;
  logic [W_DIV-1:0]   half_period;
  logic [W_DIV-1:0]   tol;
  logic [W_EDGES-1:0] min_edges;
  logic               dout;
  logic               locked;
  logic               err;

  modport master (
    output en, din, invert, half_period, tol, min_edges,
    input  dout, locked, err
  );

  modport slave (
    input  en, din, invert, half_period, tol, min_edges,
    output dout, locked, err
  );
endinterface

// File: rtl/ir_demod.sv
// IR carrier demodulator: qualifies edge-to-edge intervals against an expected half-period
// and emits a UART baseband stream (0 while carrier is present, 1 otherwise).
module ir_demod #(
  parameter int W_DIV   = 12,
  parameter int W_EDGES = 4
) (
  input  logic         clk,
  input  logic         rst_n_sync,
  ir_demod_if.slave    bus
);

  localparam int W_CTR = W_DIV + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state;
  logic               din_q;
  logic [W_CTR-1:0]   ctr;
  logic [W_EDGES-1:0] vcount;
  logic               locked_q;
  logic               dout_q;
  logic               err_q;

  logic               din_eff;
  logic               edge_seen;
  logic [W_CTR-1:0]   hp_x;
  logic [W_CTR-1:0]   tol_x;
  logic [W_CTR-1:0]   hi;
  logic [W_CTR-1:0]   lo;
  logic [W_CTR-1:0]   twice_hp;
  logic               valid;
  logic               timeout;
  logic               hp_zero;
  logic [W_EDGES:0]   need_edges;
  logic [W_EDGES:0]   vcount_inc;

  assign din_eff    = bus.din ^ bus.invert;
  assign edge_seen  = din_eff ^ din_q;

  // Interval window evaluated one bit wider than the settings, so hi and 2*half_period never wrap.
  assign hp_x       = {1'b0, bus.half_period};
  assign tol_x      = {1'b0, bus.tol};
  assign hi         = hp_x + tol_x;
  assign lo         = (bus.tol >= bus.half_period) ? W_CTR'(1) : (hp_x - tol_x);
  assign twice_hp   = {bus.half_period, 1'b0};
  assign valid      = (ctr >= lo) && (ctr <= hi);
  assign timeout    = !edge_seen && (ctr >= twice_hp);
  assign hp_zero    = (bus.half_period == '0);
  assign need_edges = (bus.min_edges == '0) ? (W_EDGES+1)'(1) : {1'b0, bus.min_edges};
  assign vcount_inc = {1'b0, vcount} + (W_EDGES+1)'(1);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state    <= IDLE;
      din_q    <= 1'b0;
      ctr      <= '0;
      vcount   <= '0;
      locked_q <= 1'b0;
      dout_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      // din_q tracks even while disabled so raising en cannot fabricate an edge.
      din_q <= din_eff;
      err_q <= 1'b0;
      if (!bus.en) begin
        state    <= IDLE;
        ctr      <= '0;
        vcount   <= '0;
        locked_q <= 1'b0;
        dout_q   <= 1'b1;
      end else begin
        if (edge_seen)
          ctr <= W_CTR'(1);
        else if (ctr != {W_CTR{1'b1}})
          ctr <= ctr + W_CTR'(1);

        if (hp_zero) begin
          state    <= IDLE;
          vcount   <= '0;
          locked_q <= 1'b0;
          dout_q   <= 1'b1;
        end else begin
          unique case (state)
            IDLE: begin
              if (edge_seen) begin
                state  <= ACQUIRE;
                vcount <= '0;
              end
            end
            ACQUIRE: begin
              if (edge_seen) begin
                if (valid) begin
                  vcount <= vcount_inc[W_EDGES-1:0];
                  if (vcount_inc >= need_edges) begin
                    state    <= LOCKED;
                    locked_q <= 1'b1;
                    dout_q   <= 1'b0;
                  end
                end else begin
                  vcount <= '0;
                end
              end else if (timeout) begin
                state <= IDLE;
              end
            end
            LOCKED: begin
              if (edge_seen) begin
                if (!valid) err_q <= 1'b1;
              end else if (timeout) begin
                state    <= IDLE;
                locked_q <= 1'b0;
                dout_q   <= 1'b1;
              end
            end
            default: begin
              state    <= IDLE;
              locked_q <= 1'b0;
              dout_q   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.dout   = dout_q;
  assign bus.locked = locked_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_ir_demod.sv
// Self-checking bench for ir_demod: a timestamp-based carrier model checked every cycle,
// plus hand-computed literal expectations at the key instants.
module tb_ir_demod;

  localparam int W_DIV   = 12;
  localparam int W_EDGES = 4;
  localparam int SAT     = (1 << (W_DIV + 1)) - 1;
  localparam int BIT_T   = 208;

  logic clk = 1'b0;
  logic rst_n_sync = 1'b0;
  always #5 clk = ~clk;

  ir_demod_if #(.W_DIV(W_DIV), .W_EDGES(W_EDGES)) bus ();

  ir_demod #(.W_DIV(W_DIV), .W_EDGES(W_EDGES)) dut (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .bus        (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: carrier described by the time of the last edge (ref_c) and a phase 0/1/2 =
  // no carrier / counting good intervals / carrier present.
  int n, ref_c, vc, mode, age, lo, hi, need, hp, tl;
  bit prev, lvl, e, m_err;

  always @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      n = 0; ref_c = 1; vc = 0; mode = 0; prev = 0; m_err = 0;
    end else begin
      n++;
      lvl  = bus.din ^ bus.invert;
      e    = (lvl != prev);
      prev = lvl;
      age  = n - ref_c;
      if (age > SAT) age = SAT;
      hp   = int'(bus.half_period);
      tl   = int'(bus.tol);
      hi   = hp + tl;
      lo   = (tl >= hp) ? 1 : hp - tl;
      need = (bus.min_edges == 0) ? 1 : int'(bus.min_edges);
      m_err = 0;
      if (!bus.en) begin
        mode = 0; vc = 0; ref_c = n + 1;
      end else begin
        if (hp == 0) begin
          mode = 0; vc = 0;
        end else if (e) begin
          if (mode == 0) begin
            mode = 1; vc = 0;
          end else if (age >= lo && age <= hi) begin
            if (mode == 1) begin
              vc++;
              if (vc >= need) mode = 2;
            end
          end else begin
            if (mode == 1) vc = 0;
            else m_err = 1;
          end
        end else if (age >= 2 * hp) begin
          mode = 0;
        end
        if (e) ref_c = n;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_sync) begin
      check("model_locked", int'(bus.locked), (mode == 2) ? 1 : 0);
      check("model_dout",   int'(bus.dout),   (mode == 2) ? 0 : 1);
      check("model_err",    int'(bus.err),    int'(m_err));
    end
  end

  task automatic gap(input int p);
    repeat (p) @(negedge clk);
    bus.din = ~bus.din;
  endtask

  task automatic train(input int p, input int cnt);
    repeat (cnt) gap(p);
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    logic [9:0] got;
    frame = {1'b1, b, 1'b0};
    got   = '0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < BIT_T; j++) begin
        @(negedge clk);
        if (j == 120) got[k] = bus.dout;
        if (!frame[k] && (j % 13 == 12)) bus.din = ~bus.din;
      end
    end
    check("loop_start", int'(got[0]), 0);
    check("loop_stop",  int'(got[9]), 1);
    check("loop_data",  int'(got[8:1]), int'(b));
  endtask

  initial begin
    bus.en = 1'b0; bus.din = 1'b0; bus.invert = 1'b0;
    bus.half_period = 12'd13; bus.tol = 12'd2; bus.min_edges = 4'd4;
    repeat (3) @(negedge clk);
    rst_n_sync = 1'b1;
    @(negedge clk);
    check("rst_dout",   int'(bus.dout), 1);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err",    int'(bus.err), 0);

    bus.en = 1'b1;
    repeat (20) @(negedge clk);
    check("static_en_locked", int'(bus.locked), 0);

    // Lock exactly one cycle after the 5th edge, unlock when ctr reaches 26.
    train(13, 4);
    @(negedge clk);
    check("lock_after_4th", int'(bus.locked), 0);
    gap(12);
    @(negedge clk);
    check("lock_after_5th", int'(bus.locked), 1);
    check("dout_after_5th", int'(bus.dout), 0);
    repeat (25) @(negedge clk);
    check("hold_ctr_25", int'(bus.locked), 1);
    @(negedge clk);
    check("drop_ctr_26", int'(bus.locked), 0);
    settle();

    gap(11); gap(15); gap(11); gap(15); gap(11);
    @(negedge clk);
    check("tol_11_15_lock", int'(bus.locked), 1);
    settle();
    train(10, 10);
    @(negedge clk);
    check("tol_10_nolock", int'(bus.locked), 0);
    settle();
    train(16, 10);
    @(negedge clk);
    check("tol_16_nolock", int'(bus.locked), 0);
    settle();

    train(13, 6);
    gap(16);
    @(negedge clk);
    check("lone16_err",    int'(bus.err), 1);
    check("lone16_locked", int'(bus.locked), 1);
    @(negedge clk);
    check("lone16_err_end", int'(bus.err), 0);
    gap(11);
    settle();

    train(13, 6);
    gap(5);
    @(negedge clk);
    check("glitch_err",    int'(bus.err), 1);
    check("glitch_locked", int'(bus.locked), 1);
    gap(4);
    @(negedge clk);
    check("glitch2_err", int'(bus.err), 1);
    gap(12);
    settle();
    train(8, 12);
    @(negedge clk);
    check("toggle8_nolock", int'(bus.locked), 0);
    settle();

    for (int inv = 0; inv < 2; inv++) begin
      bus.en = 1'b0;
      bus.invert = inv[0];
      @(negedge clk);
      bus.en = 1'b1;
      repeat (5) @(negedge clk);
      train(13, 6);
      @(negedge clk);
      check("en_pre_locked", int'(bus.locked), 1);
      bus.en = 1'b0;
      @(negedge clk);
      check("en_drop_dout", int'(bus.dout), 1);
      bus.din = ~bus.din;
      repeat (2) @(negedge clk);
      bus.en = 1'b1;
      repeat (30) @(negedge clk);
      check("en_rise_idle", int'(bus.locked), 0);
    end
    bus.invert = 1'b0;

    bus.min_edges = 4'd0;
    gap(13); gap(13);
    @(negedge clk);
    check("min_edges0_lock", int'(bus.locked), 1);
    settle();
    bus.min_edges = 4'd4;

    bus.half_period = 12'd0;
    train(13, 8);
    @(negedge clk);
    check("hp0_nolock", int'(bus.locked), 0);
    bus.half_period = 12'd13;
    settle();

    bus.half_period = 12'd3; bus.tol = 12'd5;
    train(1, 5);
    @(negedge clk);
    check("clamp_lo_lock", int'(bus.locked), 1);
    repeat (20) @(negedge clk);
    bus.half_period = 12'd13; bus.tol = 12'd2;
    settle();

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hFF);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
